// File: rtl/mc_inject_ctrl.sv
// mc_inject_ctrl: injection-side requester for the multicast switch allocator.
// Queues locally injected flits and presents the oldest one (the head) to the
// allocator. For multicast heads, ports that have been delivered are stripped
// from the pending port vector, and the residue is re-presented until it is empty.
// The head stays in its FIFO slot until it retires. Only its pending ppv is
// copied into a separate register, which is the only field that changes while
// the flit is waiting.
module mc_inject_ctrl #(
    parameter int DEPTH     = 4,
    parameter int PPV_W     = 4,
    parameter int CNT_W     = 3,
    parameter int DATA_W    = 64,
    parameter int STARVE_TH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enq_valid,
    input  logic              enq_mc,
    input  logic [PPV_W-1:0]  enq_ppv,
    input  logic [DATA_W-1:0] enq_data,
    output logic              enq_ready,
    input  logic              slot_free,
    input  logic [CNT_W-1:0]  occ,
    output logic              req_valid,
    output logic              req_mc,
    output logic [PPV_W-1:0]  req_ppv,
    output logic [DATA_W-1:0] req_data,
    output logic [CNT_W-1:0]  req_numflit,
    input  logic [PPV_W-1:0]  grant_pv,
    output logic              starve,
    output logic [15:0]       copies_sent
);

    localparam int              PtrW      = $clog2(DEPTH);
    localparam logic [PtrW:0]   FullCount = (PtrW + 1)'(DEPTH);
    localparam logic [3:0]      StarveTh  = 4'(STARVE_TH);

    typedef struct packed {
        logic              mc;
        logic [PPV_W-1:0]  ppv;
        logic [DATA_W-1:0] data;
    } flit_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FRESH   = 2'd1,
        PARTIAL = 2'd2
    } headState_t;

    flit_t            fifoMem [DEPTH];
    flit_t            headEntry;
    flit_t            nextEntry;
    logic [PtrW-1:0]  wrPtr;
    logic [PtrW-1:0]  rdPtr;
    logic [PtrW-1:0]  rdPtrNext;
    logic [PtrW:0]    count;
    headState_t       state;
    headState_t       nextState;
    logic [PPV_W-1:0] headPpv;
    logic [PPV_W-1:0] hit;
    logic [PPV_W-1:0] rem;
    logic             headValid;
    logic             doEnq;
    logic             fifoNonEmpty;
    logic             retire;
    logic             partialUpd;
    logic             starveInc;
    logic             loadFromEmpty;
    logic             loadNext;
    logic [3:0]       starveCnt;
    logic [15:0]      copiesInc;
    logic [15:0]      copiesCnt;

    // Counts the set bits in a port vector. The result is widened to match the copy counter.
    function automatic logic [15:0] popCount(input logic [PPV_W-1:0] v);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < PPV_W; i++) begin
            n = n + 16'(v[i]);
        end
        return n;
    endfunction

    assign headValid    = (state != EMPTY);
    assign fifoNonEmpty = (count != '0);
    assign doEnq        = enq_valid & enq_ready;
    assign rdPtrNext    = rdPtr + PtrW'(1);
    assign headEntry    = fifoMem[rdPtr];
    assign nextEntry    = fifoMem[rdPtrNext];

    assign enq_ready    = (count != FullCount);
    assign req_valid    = headValid & slot_free;
    assign req_mc       = headValid & headEntry.mc;
    assign req_ppv      = headPpv;
    assign req_data     = headValid ? headEntry.data : '0;
    assign req_numflit  = (occ == '1) ? occ : occ + CNT_W'(1);
    assign starve       = (starveCnt >= StarveTh);
    assign copies_sent  = copiesCnt;

    // Decode the allocator response for the presented head and choose the next state.
    always_comb begin
        // NOTE: every signal gets a default value first. If any path left one unassigned, synthesis would infer a latch.
        nextState     = state;
        retire        = 1'b0;
        partialUpd    = 1'b0;
        starveInc     = 1'b0;
        copiesInc     = '0;
        hit           = grant_pv & headPpv;
        rem           = headPpv & ~grant_pv;

        if (req_valid) begin
            if (grant_pv == '0) begin
                starveInc = 1'b1;
            end else if (!headEntry.mc) begin
                // A unicast head leaves on any grant, including a deflected one.
                retire    = 1'b1;
                copiesInc = 16'd1;
            end else if (rem == '0) begin
                // Nothing left to deliver. This branch also covers a head whose ppv was empty.
                retire    = 1'b1;
                copiesInc = popCount(hit);
            end else if (hit == '0) begin
                // The multicast head was deflected outright, so it made no progress.
                starveInc = 1'b1;
            end else begin
                partialUpd = 1'b1;
                copiesInc  = popCount(hit);
            end
        end

        loadFromEmpty = (state == EMPTY) && fifoNonEmpty;
        loadNext      = retire && (count > (PtrW + 1)'(1));

        case (state)
            EMPTY:   if (fifoNonEmpty) nextState = FRESH;
            FRESH,
            PARTIAL: begin
                if (retire)          nextState = loadNext ? FRESH : EMPTY;
                else if (partialUpd) nextState = PARTIAL;
            end
            default: nextState = EMPTY;
        endcase
    end

    // Head state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state elements use non-blocking assignments so that every flop samples its pre-edge value.
        if (reset) state <= EMPTY;
        else       state <= nextState;
    end

    // FIFO storage: write the offered flit into the tail slot.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset. Pointers and count define which slots are valid, so stale contents are never observed.
        if (doEnq) fifoMem[wrPtr] <= '{mc: enq_mc, ppv: enq_ppv, data: enq_data};
    end

    // FIFO pointers and occupancy. The head slot is popped only when the head retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doEnq)  wrPtr <= wrPtr + PtrW'(1);
            if (retire) rdPtr <= rdPtrNext;
            case ({doEnq, retire})
                2'b10:   count <= count + (PtrW + 1)'(1);
                2'b01:   count <= count - (PtrW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Pending ppv of the head: copy it on load, strip delivered ports, clear it when the FIFO drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headPpv <= '0;
        end else if (loadFromEmpty) begin
            headPpv <= headEntry.ppv;
        end else if (loadNext) begin
            headPpv <= nextEntry.ppv;
        end else if (retire) begin
            headPpv <= '0;
        end else if (partialUpd) begin
            headPpv <= rem;
        end
    end

    // Saturating counter of consecutive unproductive issues, plus the wrapping total of copies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starveCnt <= '0;
            copiesCnt <= '0;
        end else begin
            if (retire || partialUpd)           starveCnt <= '0;
            else if (starveInc && starveCnt != 4'hF) starveCnt <= starveCnt + 4'd1;
            copiesCnt <= copiesCnt + copiesInc;
        end
    end

endmodule

// File: doc/mc_inject_ctrl.md
Name: mc_inject_ctrl

Overview:
- Requester-side counterpart of the multicast switch allocator in the bufferless router.
- Buffers locally injected flits, presents the head flit to the allocator, and consumes the returned allocated port vector.
- For multicast, clears delivered ports from the head's pending productive port vector (ppv) and re-presents the residue until all destinations are served.
- Sits between the node's injection queue and the router's lowest-priority input channel.

Parameters:
- DEPTH, 4, injection FIFO entries (power of 2, ≥2)
- PPV_W, 4, port-vector width (NUM_PORT-1)
- CNT_W, 3, flit-count width (PC_INDEX_WIDTH)
- DATA_W, 64, payload width
- STARVE_TH, 8, consecutive unproductive issues before starve is raised

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enq_valid  in  1  new flit offered
- enq_mc  in  1  new flit is multicast
- enq_ppv  in  PPV_W  productive ports of new flit
- enq_data  in  DATA_W  payload
- enq_ready  out  1  FIFO can accept
- slot_free  in  1  router input channel empty this cycle
- occ  in  CNT_W  flits already in router this cycle
- req_valid  out  1  head presented to allocator
- req_mc  out  1  head multicast flag
- req_ppv  out  PPV_W  head pending ppv
- req_data  out  DATA_W  head payload
- req_numflit  out  CNT_W  numFlit to allocator
- grant_pv  in  PPV_W  allocated port vector for the head, same cycle, combinational from the allocator
- starve  out  1  head starving, raise priority
- copies_sent  out  16  total granted copies, wraps

Behaviour:
- Reset (async, immediate): FIFO empty, head invalid, state EMPTY, starve=0, copies_sent=0. Outputs: req_valid=0, req_mc=0, req_ppv=0, req_data=0, enq_ready=1. An in-flight partial multicast is discarded.
- FIFO:
  - enq_ready = (count != DEPTH), from registered count only.
  - Enqueue when enq_valid & enq_ready.
  - No enqueue-to-issue bypass: a flit enqueued at edge N reaches req_valid at N+1 at the earliest.
  - Head load happens at the edge after the head retires or the FIFO becomes non-empty.
- States:
  - EMPTY: no head. Go to FRESH when the FIFO is non-empty (head loaded from the FIFO, ppv copied).
  - FRESH: head holds its original ppv.
  - PARTIAL: head is multicast with some ports already delivered.
- Issue: req_valid = head_valid & slot_free. req_* always reflect the head register.
- req_numflit = occ+1, saturating at 2^CNT_W-1.
- Edge update when req_valid, with g = grant_pv:
  - g==0: no change; starve counter +1.
  - Unicast (req_mc=0) and g≠0: retire the head, including deflected grants. copies_sent += 1.
  - Multicast, rem = req_ppv & ~g:
    - rem==0: retire.
    - rem≠0: head ppv←rem, state PARTIAL, starve counter reset.
    - If g & req_ppv == 0 (pure deflection of a multicast head): no change, starve counter +1.
    - In all multicast cases, copies_sent += popcount(g & req_ppv).
- Retire: if the FIFO is non-empty, load the next head in the same edge (state FRESH); else go to EMPTY.
- Starve counter: 4-bit, saturating. starve = counter ≥ STARVE_TH (registered). Cleared on retire or any productive grant.
- grant_pv bits set while req_valid=0 are ignored.
- An enqueue with enq_ppv==0 is accepted and retires on its first nonzero grant.
- Simultaneous enqueue and retire while full: enq_ready was 0, so no enqueue occurs; the retire still happens.
- copies_sent wraps 0xFFFF→0.

Test Plan:
- Reset mid-PARTIAL (head ppv 0101 after one grant): assert reset → req_valid=0, enq_ready=1, copies_sent=0 with no clock edge.
- Unicast enq ppv=0010, slot_free=1, grant=1000 (deflected) → head retires at the same edge, copies_sent=1, req_valid=0 next cycle.
- Multicast ppv=1011: grant=0001 → req_ppv=1010, PARTIAL. Then grant=1010 → retire. copies_sent=3.
- Fill 4 flits with slot_free=0 → enq_ready=0 after the 4th. Then slot_free=1 with retire each cycle → enq_ready=1 one cycle after the first retire.
- Multicast head, grant=0000 for 8 issued cycles → starve=1 after the 8th edge. A productive grant clears starve.
- occ=7 → req_numflit=7 (saturated). occ=2 → req_numflit=3.
